// File: rtl/spu_pre.sv
// Float-to-fixed input stage of the sigmoid unit: IEEE-754 single -> signed Q(31-FRAC_BITS).FRAC_BITS.
// Latency: 2 clocks (decode register, then shift/saturate output register); one word per clock.
// Backpressure: out_ready low holds the output register and stalls decode; in_ready drops only when both stages are full.
module spu_pre #(
    parameter int FRAC_BITS = 24,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_float,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_fixed,
    output logic             out_sat,
    output logic             out_nan,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] sat_count
);

    typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;

    // sh = exp - 127 + FRAC_BITS - 23, folded into a single 10-bit bias
    localparam logic [9:0]  SH_BIAS = 10'(FRAC_BITS - 150);
    localparam logic [31:0] POS_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_MAX = 32'h8000_0000;

    logic              r_s1_vld;
    logic              r_s1_sign;
    logic [23:0]       r_s1_mag;
    cls_t              r_s1_cls;
    logic signed [9:0] r_s1_sh;

    logic              r_out_vld;
    logic [31:0]       r_out_fixed;
    logic              r_out_sat;
    logic              r_out_nan;
    logic [CNT_W-1:0]  r_sat_cnt;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [7:0]        w_exp;
    logic [22:0]       w_mant;
    cls_t              w_in_cls;

    logic [9:0]        w_nsh;
    logic [31:0]       w_lsh;
    logic [31:0]       w_rsh;
    logic [31:0]       w_mag;
    logic [31:0]       w_fix;
    logic              w_sat;
    logic              w_nan;

    assign w_s2_adv = !r_out_vld || out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1_vld;
    assign in_ready = w_s1_adv;

    assign w_exp  = in_float[30:23];
    assign w_mant = in_float[22:0];

    always_comb begin
        w_in_cls = CL_NORM;
        if (w_exp == 8'h00)
            w_in_cls = CL_ZERO;
        else if (w_exp == 8'hFF)
            w_in_cls = (w_mant == 23'd0) ? CL_INF : CL_NAN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_mag  <= '0;
            r_s1_cls  <= CL_ZERO;
            r_s1_sh   <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_float[31];
                r_s1_mag  <= {1'b1, w_mant};
                r_s1_cls  <= w_in_cls;
                r_s1_sh   <= signed'({2'b00, w_exp} + SH_BIAS);
            end
        end
    end

    // Leading one sits at bit 23+sh, so sh >= 8 always reaches 2^31; smaller left shifts fit in 31 bits
    assign w_nsh = 10'(-r_s1_sh);
    assign w_lsh = {8'd0, r_s1_mag} << r_s1_sh[2:0];
    assign w_rsh = (w_nsh >= 10'd24) ? 32'd0 : ({8'd0, r_s1_mag} >> w_nsh[4:0]);
    assign w_mag = r_s1_sh[9] ? w_rsh : w_lsh;

    always_comb begin
        w_fix = 32'd0;
        w_sat = 1'b0;
        w_nan = 1'b0;
        case (r_s1_cls)
            CL_NAN: w_nan = 1'b1;
            CL_INF: begin
                w_sat = 1'b1;
                w_fix = r_s1_sign ? NEG_MAX : POS_MAX;
            end
            CL_NORM: begin
                if (r_s1_sh >= 10'sd8) begin
                    // -2^31 exactly is representable and is not a clamp
                    if (r_s1_sign && r_s1_sh == 10'sd8 && r_s1_mag[22:0] == 23'd0) begin
                        w_fix = NEG_MAX;
                    end else begin
                        w_sat = 1'b1;
                        w_fix = r_s1_sign ? NEG_MAX : POS_MAX;
                    end
                end else begin
                    w_fix = r_s1_sign ? (32'd0 - w_mag) : w_mag;
                end
            end
            default: w_fix = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_fixed <= '0;
            r_out_sat   <= 1'b0;
            r_out_nan   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_fixed <= w_fix;
                r_out_sat   <= w_sat;
                r_out_nan   <= w_nan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (cnt_clr)
            r_sat_cnt <= '0;
        else if (r_out_vld && out_ready && r_out_sat && !(&r_sat_cnt))
            r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign out_valid = r_out_vld;
    assign out_fixed = r_out_fixed;
    assign out_sat   = r_out_sat;
    assign out_nan   = r_out_nan;
    assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_spu_pre.sv
// Bench for spu_pre: table of float -> fixed vectors fed through a scoreboard queue,
// plus hand sequences for latency, stall stability, counter clear and mid-flight reset.
module tb_spu_pre;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      in_float = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      out_fixed;
    logic             out_sat;
    logic             out_nan;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] sat_count;

    spu_pre #(.FRAC_BITS(24), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_float(in_float), .in_valid(in_valid), .in_ready(in_ready),
        .out_fixed(out_fixed), .out_sat(out_sat), .out_nan(out_nan),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [31:0] fx;
        logic        sat;
        logic        nan;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];
    vec_t q [$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   mdl_cnt = 0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_fix;
    logic        hold_sat, hold_nan;
    bit          stream_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Output monitor: handshake decided by values stable at the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            vec_t e;
            logic hs;
            hs = out_valid && out_ready;
            if (hold_vld && out_valid) begin
                chk("stall_fixed", out_fixed, hold_fix);
                chk("stall_flags", {30'd0, out_sat, out_nan}, {30'd0, hold_sat, hold_nan});
            end
            if (out_valid)
                chk("sat_nan_excl", {31'd0, out_sat && out_nan}, 32'd0);
            if (hs) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_fixed);
                end else begin
                    e = q.pop_front();
                    chk("out_fixed", out_fixed, e.fx);
                    chk("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
                    chk("out_nan", {31'd0, out_nan}, {31'd0, e.nan});
                    if (!cnt_clr && e.sat) mdl_cnt++;
                end
            end
            if (cnt_clr) mdl_cnt = 0;
            hold_vld = out_valid && !out_ready;
            hold_fix = out_fixed;
            hold_sat = out_sat;
            hold_nan = out_nan;
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Present one word; returns at posedge+1 so consecutive calls stream back-to-back
    task automatic send(input vec_t v);
        bit acc;
        acc = 1'b0;
        in_float = v.f;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(v);
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected accept of %h", v.f);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        vt[0]  = '{32'h3F800000, 32'h01000000, 1'b0, 1'b0};
        vt[1]  = '{32'h3F400000, 32'h00C00000, 1'b0, 1'b0};
        vt[2]  = '{32'hC0200000, 32'hFD800000, 1'b0, 1'b0};
        vt[3]  = '{32'hC3000000, 32'h80000000, 1'b0, 1'b0};
        vt[4]  = '{32'h43480000, 32'h7FFFFFFF, 1'b1, 1'b0};
        vt[5]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0};
        vt[6]  = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1};
        vt[7]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0};
        vt[8]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b0};
        vt[9]  = '{32'h33000000, 32'h00000000, 1'b0, 1'b0};
        vt[10] = '{32'h33800000, 32'h00000001, 1'b0, 1'b0};
        vt[11] = '{32'h42FF0000, 32'h7F800000, 1'b0, 1'b0};
        vt[12] = '{32'hC2FF0000, 32'h80800000, 1'b0, 1'b0};
        vt[13] = '{32'hC3000001, 32'h80000000, 1'b1, 1'b0};
        vt[14] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0};
        vt[15] = '{32'hBF000000, 32'hFF800000, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_fixed", out_fixed, 32'd0);
        chk("rst_flags", {30'd0, out_sat, out_nan}, 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Latency: accepted in cycle c, out_valid in cycle c+2
        in_float = vt[0].f;
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        q.push_back(vt[0]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Two saturating words from a fresh counter
        send(vt[4]);
        send(vt[5]);
        drain();
        chk("sat_count_two", 32'(sat_count), 32'd2);

        // Full table, no backpressure
        foreach (vt[i]) send(vt[i]);
        drain();
        chk("sat_count_table", 32'(sat_count), 32'(mdl_cnt));

        // Back-to-back stream with random downstream stalls
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vt[(i * 3 + 1) % NV]);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("sat_count_stream", 32'(sat_count), 32'(mdl_cnt));

        // Clear wins over a simultaneous saturating handshake
        out_ready = 1'b0;
        send(vt[14]);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("clr_pending_valid", {31'd0, out_valid}, 32'd1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("sat_count_cleared", 32'(sat_count), 32'd0);
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send(vt[0]);
        send(vt[2]);
        rst_n = 1'b0;
        #1;
        chk("inflight_rst_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        mdl_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(vt[1]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

endmodule
